// File: rtl/bcd_interval_sched_pkg.sv
// bcd_interval_sched_pkg: shared state encoding, BCD constants and helpers
package bcd_interval_sched_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, RUN, FIN, REL} state_t;
  localparam logic [7:0] BCD_MAX = 8'h99;
  localparam logic [7:0] BCD_ZERO = 8'h00;
  function automatic logic nib_ok(input logic [3:0] n);
    return n <= 4'd9;
  endfunction
  function automatic logic bcd_ok(input logic [7:0] v);
    return nib_ok(v[7:4]) && nib_ok(v[3:0]);
  endfunction
  // Valid BCD orders the same as its binary image, so a plain compare suffices
  function automatic logic bcd_lt(input logic [7:0] a, input logic [7:0] b);
    return a < b;
  endfunction
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v == BCD_MAX) return BCD_ZERO;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction
endpackage

// File: rtl/bcd_interval_sched_bcd2_counter.sv
// bcd2_counter: two-digit BCD up-counter with clear, load and enable, wrapping 99 to 00
module bcd2_counter
  import bcd_interval_sched_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  input  logic       ld,
  input  logic       en,
  input  logic [7:0] d,
  output logic [7:0] q
);
  // Clear beats load beats count
  always_ff @(posedge clk)
    q <= clr ? BCD_ZERO : ld ? d : en ? bcd_inc(q) : q;
endmodule

// File: rtl/bcd_interval_sched.sv
// bcd_interval_sched: round-robin owner of a shared BCD counter running start-to-stop intervals
module bcd_interval_sched
  import bcd_interval_sched_pkg::*;
#(
  parameter bit ALLOW_WRAP = 1'b1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       TICK,
  input  logic       REQ0,
  input  logic       REQ1,
  input  logic [7:0] START0,
  input  logic [7:0] START1,
  input  logic [7:0] STOP0,
  input  logic [7:0] STOP1,
  output logic       GNT0,
  output logic       GNT1,
  output logic       DONE0,
  output logic       DONE1,
  output logic       ERR0,
  output logic       ERR1,
  output logic [7:0] CNT,
  output logic       BUSY
);
  state_t state, state_n;
  logic owner, owner_n, ptr, ptr_n, win, own_req, bad, ld, en;
  logic [7:0] start_r, stop_r, start_n, stop_n, win_start, win_stop;
  logic [1:0] gnt, gnt_n, done, done_n, err, err_n;
  assign own_req = owner ? REQ1 : REQ0;
  assign win = (REQ0 && REQ1) ? ptr : REQ1;
  assign win_start = win ? START1 : START0;
  assign win_stop = win ? STOP1 : STOP0;
  assign bad = !bcd_ok(win_start) || !bcd_ok(win_stop) || (!ALLOW_WRAP && bcd_lt(win_stop, win_start));
  assign ld = state == LOAD && own_req;
  assign en = state == RUN && own_req && TICK;
  assign {GNT1, GNT0} = gnt;
  assign {DONE1, DONE0} = done;
  assign {ERR1, ERR0} = err;
  assign BUSY = state != IDLE;
  bcd2_counter u_cnt (
    .clk(CLK),
    .clr(RST),
    .ld (ld),
    .en (en),
    .d  (start_r),
    .q  (CNT)
  );
  // Next-state and next-output decode; dropping the owner's request releases from LOAD/RUN/REL
  always_comb begin
    state_n = state;
    owner_n = owner;
    ptr_n = ptr;
    start_n = start_r;
    stop_n = stop_r;
    gnt_n = gnt;
    done_n = '0;
    err_n = '0;
    case (state)
      IDLE: if (REQ0 || REQ1) begin
        owner_n = win;
        start_n = win_start;
        stop_n = win_stop;
        err_n[win] = bad;
        gnt_n[win] = !bad;
        state_n = bad ? REL : LOAD;
      end
      LOAD, RUN: if (!own_req) begin
        gnt_n = '0;
        ptr_n = !owner;
        state_n = IDLE;
      end else if (state == LOAD) state_n = start_r == stop_r ? FIN : RUN;
      else if (TICK && bcd_inc(CNT) == stop_r) state_n = FIN;
      FIN: begin
        done_n[owner] = 1'b1;
        state_n = REL;
      end
      REL: if (!own_req) begin
        gnt_n = '0;
        ptr_n = !owner;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  // Registered state and outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      owner <= 1'b0;
      ptr <= 1'b0;
      start_r <= BCD_ZERO;
      stop_r <= BCD_ZERO;
      gnt <= '0;
      done <= '0;
      err <= '0;
    end else begin
      state <= state_n;
      owner <= owner_n;
      ptr <= ptr_n;
      start_r <= start_n;
      stop_r <= stop_n;
      gnt <= gnt_n;
      done <= done_n;
      err <= err_n;
    end
  end
endmodule

// File: tb/tb_bcd_interval_sched.sv
// tb_bcd_interval_sched: table, directed and random checks of the interval scheduler
module tb_bcd_interval_sched;
  logic clk = 1'b0, rst = 1'b0, tick = 1'b0;
  logic [1:0] r0 = '0, r1 = '0;
  logic [7:0] st0 = '0, st1 = '0, sp0 = '0, sp1 = '0;
  logic [1:0] g0, g1, d0, d1, e0, e1, busy;
  logic [7:0] ca, cb;
  logic [7:0] mcnt [2];
  int tests = 0, fails = 0;
  typedef struct { int id; int w; logic [7:0] st; logic [7:0] sp; bit xe; int xt; } vec_t;
  vec_t tbl [9];

  always #5 clk = ~clk;

  bcd_interval_sched #(.ALLOW_WRAP(1'b1)) dut (
    .CLK(clk), .RST(rst), .TICK(tick), .REQ0(r0[0]), .REQ1(r1[0]),
    .START0(st0), .START1(st1), .STOP0(sp0), .STOP1(sp1),
    .GNT0(g0[0]), .GNT1(g1[0]), .DONE0(d0[0]), .DONE1(d1[0]),
    .ERR0(e0[0]), .ERR1(e1[0]), .CNT(ca), .BUSY(busy[0])
  );
  bcd_interval_sched #(.ALLOW_WRAP(1'b0)) dutn (
    .CLK(clk), .RST(rst), .TICK(tick), .REQ0(r0[1]), .REQ1(r1[1]),
    .START0(st0), .START1(st1), .STOP0(sp0), .STOP1(sp1),
    .GNT0(g0[1]), .GNT1(g1[1]), .DONE0(d0[1]), .DONE1(d1[1]),
    .ERR0(e0[1]), .ERR1(e1[1]), .CNT(cb), .BUSY(busy[1])
  );

  function automatic logic gnt_of(input int w, input int id);
    return id != 0 ? g1[w] : g0[w];
  endfunction
  function automatic logic done_of(input int w, input int id);
    return id != 0 ? d1[w] : d0[w];
  endfunction
  function automatic logic err_of(input int w, input int id);
    return id != 0 ? e1[w] : e0[w];
  endfunction
  function automatic logic [7:0] cnt_of(input int w);
    return w != 0 ? cb : ca;
  endfunction
  function automatic int bi(input logic [7:0] v);
    return int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction
  function automatic logic [7:0] to_bcd(input int v);
    return 8'((v / 10) * 16 + v % 10);
  endfunction
  function automatic bit valid(input logic [7:0] v);
    return v[7:4] < 4'd10 && v[3:0] < 4'd10;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string n, input logic [7:0] a, input logic [7:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s got %h want %h", n, a, e);
    end
  endtask
  task automatic set_req(input int w, input int id, input logic v);
    if (id != 0) r1[w] = v;
    else r0[w] = v;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    mcnt[0] = 8'h00;
    mcnt[1] = 8'h00;
  endtask

  // One full interval on requester id of DUT w with expected error flag and tick count
  task automatic txn(input int w, input int id, input logic [7:0] st, input logic [7:0] sp, input bit xe, input int xt);
    if (id != 0) begin st1 = st; sp1 = sp; end
    else begin st0 = st; sp0 = sp; end
    set_req(w, id, 1'b1);
    step();
    check("err_at_grant", err_of(w, id), xe);
    check("gnt_at_grant", gnt_of(w, id), !xe);
    check("busy_at_grant", busy[w], 1);
    if (xe) begin
      step();
      check("err_one_cycle", err_of(w, id), 0);
      check("no_gnt_on_err", gnt_of(w, id), 0);
    end else begin
      step();
      check("cnt_loaded", cnt_of(w), st);
      for (int k = 1; k <= xt; k++) begin
        if ($urandom_range(3) == 0) begin
          tick = 1'b0;
          step();
          check("cnt_hold", cnt_of(w), to_bcd((bi(st) + k - 1) % 100));
        end
        tick = 1'b1;
        step();
        check("cnt_count", cnt_of(w), to_bcd((bi(st) + k) % 100));
        check("no_early_done", done_of(w, id), 0);
      end
      tick = 1'b0;
      step();
      check("done_pulse", done_of(w, id), 1);
      check("gnt_in_done", gnt_of(w, id), 1);
      mcnt[w] = sp;
      step();
      check("done_one_cycle", done_of(w, id), 0);
    end
    set_req(w, id, 1'b0);
    step();
    check("gnt_released", gnt_of(w, id), 0);
    check("busy_released", busy[w], 0);
    check("cnt_kept", cnt_of(w), mcnt[w]);
  endtask

  initial begin
    tbl[0] = '{0, 0, 8'h07, 8'h12, 1'b0, 5};
    tbl[1] = '{1, 0, 8'h98, 8'h01, 1'b0, 3};
    tbl[2] = '{1, 1, 8'h98, 8'h01, 1'b1, 0};
    tbl[3] = '{0, 0, 8'h1A, 8'h20, 1'b1, 0};
    tbl[4] = '{0, 0, 8'h33, 8'h33, 1'b0, 0};
    tbl[5] = '{1, 0, 8'h00, 8'h99, 1'b0, 99};
    tbl[6] = '{0, 1, 8'h05, 8'h09, 1'b0, 4};
    tbl[7] = '{1, 0, 8'h25, 8'h2F, 1'b1, 0};
    tbl[8] = '{0, 1, 8'h99, 8'h99, 1'b0, 0};
    do_reset();
    for (int w = 0; w < 2; w++) begin
      check("rst_cnt", cnt_of(w), 8'h00);
      check("rst_busy", busy[w], 0);
      check("rst_gnt", {g1[w], g0[w]}, 0);
      check("rst_pulses", {d1[w], d0[w], e1[w], e0[w]}, 0);
    end
    for (int i = 0; i < 9; i++) txn(tbl[i].w, tbl[i].id, tbl[i].st, tbl[i].sp, tbl[i].xe, tbl[i].xt);
    // Contention: both requesting, grants alternate with an IDLE gap between owners
    do_reset();
    st0 = 8'h10; sp0 = 8'h10; st1 = 8'h10; sp1 = 8'h10;
    r0[0] = 1'b1;
    r1[0] = 1'b1;
    step();
    for (int k = 0; k < 4; k++) begin
      check("rr_gnt0", g0[0], k % 2 == 0);
      check("rr_gnt1", g1[0], k % 2 == 1);
      step();
      step();
      check("rr_done", done_of(0, k % 2), 1);
      set_req(0, k % 2, 1'b0);
      step();
      check("rr_idle_gap", {g1[0], g0[0]}, 0);
      set_req(0, k % 2, 1'b1);
      step();
    end
    r0[0] = 1'b0;
    r1[0] = 1'b0;
    step();
    check("rr_end_busy", busy[0], 0);
    check("rr_end_cnt", ca, 8'h10);
    // Abort mid-RUN at 05 with requester 1 pending
    do_reset();
    st0 = 8'h00; sp0 = 8'h09; st1 = 8'h77; sp1 = 8'h80;
    r0[0] = 1'b1;
    step();
    step();
    r1[0] = 1'b1;
    tick = 1'b1;
    repeat (5) step();
    check("abort_cnt_before", ca, 8'h05);
    tick = 1'b0;
    r0[0] = 1'b0;
    step();
    check("abort_gnt0", g0[0], 0);
    check("abort_no_done", d0[0], 0);
    check("abort_cnt_held", ca, 8'h05);
    step();
    check("abort_next_gnt1", g1[0], 1);
    check("abort_no_late_done", d0[0], 0);
    r1[0] = 1'b0;
    step();
    check("abort_load_gnt1", g1[0], 0);
    check("abort_load_cnt", ca, 8'h05);
    check("abort_busy", busy[0], 0);
    // Reset mid-RUN at 42, then ticks must not move the counter
    st0 = 8'h40; sp0 = 8'h50;
    r0[0] = 1'b1;
    step();
    step();
    tick = 1'b1;
    step();
    step();
    check("mid_cnt", ca, 8'h42);
    r0[0] = 1'b0;
    do_reset();
    check("mid_rst_cnt", ca, 8'h00);
    check("mid_rst_gnt", g0[0], 0);
    check("mid_rst_busy", busy[0], 0);
    for (int k = 0; k < 3; k++) begin
      step();
      check("mid_tick_ignored", ca, 8'h00);
    end
    tick = 1'b0;
    // Random intervals against the decimal reference model
    for (int n = 0; n < 40; n++) begin
      int w, id, xt;
      logic [7:0] st, sp;
      bit xe;
      w = $urandom_range(1);
      id = $urandom_range(1);
      st = ($urandom_range(7) == 0) ? 8'($urandom) : to_bcd($urandom_range(99));
      sp = ($urandom_range(7) == 0) ? 8'($urandom) : to_bcd($urandom_range(99));
      xe = !valid(st) || !valid(sp) || (w == 1 && bi(sp) < bi(st));
      xt = xe ? 0 : (bi(sp) - bi(st) + 100) % 100;
      txn(w, id, st, sp, xe, xt);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/bcd_interval_sched.md
# bcd_interval_sched

Controller that shares one 2-digit BCD up-counter (00–99, LD/EN style) between two requesters. Each requester asks for an interval: load a BCD start value, count external TICK events, and finish on a BCD stop value. The block arbitrates round-robin, sequences load/enable of the counter, and reports completion or error per requester. It sits between requesting control logic and the shared decade-counter datapath.

## Interface
Parameters:
- ALLOW_WRAP, 1, 1: interval may wrap 99→00 (STOP < START legal); 0: STOP < START is rejected with ERR

Ports:
- CLK  in  1  rising-edge clock
- RST  in  1  synchronous, active-high reset
- TICK  in  1  count event; sampled only in RUN
- REQ0, REQ1  in  1  request, level; held high until DONE/ERR seen, then dropped
- START0, START1  in  8  BCD start value {tens,units}; sampled at grant
- STOP0, STOP1  in  8  BCD stop value; sampled at grant
- GNT0, GNT1  out  1  owner of counter, registered
- DONE0, DONE1  out  1  one-cycle completion pulse
- ERR0, ERR1  out  1  one-cycle reject pulse
- CNT  out  8  current BCD counter value
- BUSY  out  1  high in any state other than IDLE

## Operation
- States: IDLE, LOAD, RUN, FIN, REL.
- IDLE: if any REQ high, pick winner. Both high: the requester not served last wins. Pointer after reset favours 0. Capture winner's START/STOP into internal registers.
  - Winner's START or STOP has a nibble > 9, or ALLOW_WRAP=0 and STOP < START (as BCD value): pulse ERR_i, go REL; GNT stays 0.
  - Otherwise set GNT_i and go LOAD.
- LOAD: counter loads START (LD), go RUN. If START == STOP, go FIN directly, with no TICK needed.
- RUN: each cycle with TICK=1 enables the counter. Counter increments BCD: units 9→0 with carry; 99→00. When the incremented value equals STOP, go FIN on the same edge. TICK=0: hold.
- FIN: DONE_i high for exactly one cycle, GNT_i still high, go REL.
- REL: hold until REQ_i of the captured owner is low. Then clear GNT_i, flip the priority pointer to the other requester, and go IDLE.
- Abort: owner drops REQ_i in LOAD or RUN → clear GNT_i, no DONE, go IDLE, flip pointer. CNT holds its last value.
- The non-owner's REQ/START/STOP are ignored until IDLE.
- CNT is not cleared between intervals; it holds until the next LOAD.
- Reset (any state, including mid-RUN): state IDLE, CNT=8'h00, all GNT/DONE/ERR/BUSY=0, pointer→0.

## Timing
- All outputs registered; no combinational input→output paths.
- REQ sampled high at edge N (IDLE) → GNT_i high after edge N. CNT=START after edge N+1. BUSY high after edge N.
- TICK sampled high at edge M in RUN → CNT updated after edge M. If CNT==STOP, DONE_i high during cycle M+1 only.
- START==STOP: DONE_i high 2 cycles after the grant edge.
- ERR_i asserted the cycle after the IDLE decision; no GNT in that path.
- Back-to-back service: minimum 1 IDLE cycle between REL exit and the next grant.

## Structure
- Shared package: state enum (IDLE, LOAD, RUN, FIN, REL); constants BCD_MAX=8'h99, BCD_ZERO=8'h00; function for nibble validity (≤9) and BCD compare.
- Sub-module bcd2_counter: 8-bit BCD up-counter with synchronous clear, LD, EN; wraps 99→00. The controller drives LD in LOAD and EN=TICK in RUN. Target ~200 lines total RTL.

## Test plan
- Single request: REQ0=1, START0=8'h07, STOP0=8'h12, 5 TICKs → CNT 08,09,10,11,12; DONE0 pulse after the 5th TICK; GNT0 drops after REQ0 falls.
- Wrap: ALLOW_WRAP=1, START1=8'h98, STOP1=8'h01, 3 TICKs → CNT 99,00,01, DONE1. Same stimulus with ALLOW_WRAP=0 → ERR1 pulse, no GNT1.
- Invalid BCD: START0=8'h1A → ERR0 one cycle, CNT unchanged, BUSY returns to 0 after REQ0 drops.
- Contention: REQ0 and REQ1 both high from reset → GNT0 first. Re-request both → GNT1 next, then alternate.
- Abort: REQ0 dropped mid-RUN at CNT=8'h05 → GNT0=0 next cycle, no DONE0, CNT stays 05; pending REQ1 granted afterwards.
- Reset mid-RUN: RST=1 for 1 cycle at CNT=8'h42 → CNT=00, GNT=0, BUSY=0; TICK ignored until a new grant.
